display_ctrl: RTL and testbench

- Front-panel controller for the statistics display path.
- Debounces a page button, sequences the 3-bit page select driven into the display selector (codes 0..6: 0=syscall output, 1=PC, 2=total cycles, 3=jump count, 4=branch-taken count, 5=branch count, 6=memory data), and optionally auto-rotates pages.
- Latches the selected 32-bit value and time-multiplexes it onto eight active-low seven-segment digits.

---
 rtl/display_ctrl.sv | 159 +++++++++++++++
 tb/tb_display_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_ctrl.sv
// Front-panel display controller: debounced page button, page sequencing with
// optional auto-rotate, hold-able shadow of the selected value, 8-digit 7-seg scan.
module display_ctrl #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEBOUNCE    = 500000,
    parameter int AUTO_PERIOD = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic        hold,
    input  logic [31:0] disp_data,
    output logic [2:0]  sel_out,
    output logic        page_changed,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE);
    localparam int AUTO_W = $clog2(AUTO_PERIOD);

    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE - 1);
    localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD - 1);

    localparam logic [2:0] PAGE_SYSCALL = 3'd0;
    localparam logic [2:0] PAGE_PC      = 3'd1;
    localparam logic [2:0] PAGE_CYCLES  = 3'd2;
    localparam logic [2:0] PAGE_JUMPS   = 3'd3;
    localparam logic [2:0] PAGE_TAKEN   = 3'd4;
    localparam logic [2:0] PAGE_BRANCH  = 3'd5;
    localparam logic [2:0] PAGE_MEM     = 3'd6;

    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              db_level_q, db_level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic [2:0]        sel_q, sel_d;
    logic              page_changed_q, page_changed_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic db_expire, press, auto_expire, advance;
    logic [3:0] nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // The press fires on the same edge the debounced level rises, so the page
    // update lands 2 + DEBOUNCE cycles after a clean button edge.
    always_comb begin
        sync1_d = btn_next;
        sync2_d = sync1_q;

        db_expire  = (sync2_q != db_level_q) && (db_cnt_q == DB_MAX);
        press      = db_expire && sync2_q;
        db_level_d = db_expire ? sync2_q : db_level_q;
        if (sync2_q == db_level_q || db_expire) begin
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        auto_expire = auto_en && (auto_cnt_q == AUTO_MAX);
        advance     = press || auto_expire;
        if (!auto_en || advance) begin
            auto_cnt_d = '0;
        end else begin
            auto_cnt_d = auto_cnt_q + 1'b1;
        end

        sel_d = sel_q;
        if (advance) begin
            case (sel_q)
                PAGE_SYSCALL: sel_d = PAGE_PC;
                PAGE_PC:      sel_d = PAGE_CYCLES;
                PAGE_CYCLES:  sel_d = PAGE_JUMPS;
                PAGE_JUMPS:   sel_d = PAGE_TAKEN;
                PAGE_TAKEN:   sel_d = PAGE_BRANCH;
                PAGE_BRANCH:  sel_d = PAGE_MEM;
                default:      sel_d = PAGE_SYSCALL;
            endcase
        end
        page_changed_d = advance;

        shadow_d = hold ? shadow_q : disp_data;

        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            idx_d      = idx_q;
        end

        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        an_d   = ~(8'd1 << idx_q);
        seg_d  = {~((idx_q == 3'd0) && auto_en), hex7(nibble)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_level_q     <= 1'b0;
            db_cnt_q       <= '0;
            auto_cnt_q     <= '0;
            sel_q          <= PAGE_SYSCALL;
            page_changed_q <= 1'b0;
            shadow_q       <= '0;
            scan_cnt_q     <= '0;
            idx_q          <= 3'd0;
            an_q           <= 8'hFF;
            seg_q          <= 8'hFF;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            db_level_q     <= db_level_d;
            db_cnt_q       <= db_cnt_d;
            auto_cnt_q     <= auto_cnt_d;
            sel_q          <= sel_d;
            page_changed_q <= page_changed_d;
            shadow_q       <= shadow_d;
            scan_cnt_q     <= scan_cnt_d;
            idx_q          <= idx_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
        end
    end

    assign sel_out      = sel_q;
    assign page_changed = page_changed_q;
    assign an           = an_q;
    assign seg          = seg_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Self-checking bench for display_ctrl with small timing parameters: scan order,
// decode table, debounce latency, page sequencing, auto-rotate, hold and reset.
module tb_display_ctrl;

    localparam int SCAN_DIV    = 4;
    localparam int DEBOUNCE    = 8;
    localparam int AUTO_PERIOD = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_next;
    logic        auto_en;
    logic        hold;
    logic [31:0] disp_data;
    logic [2:0]  sel_out;
    logic        page_changed;
    logic [7:0]  an;
    logic [7:0]  seg;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } hex_vec_t;

    hex_vec_t   hex_tbl[16];
    logic [15:0] scan_sb[$];
    logic [2:0]  sel_sb[$];

    int checks   = 0;
    int errors   = 0;
    int pc_count = 0;
    int exp_sel  = 0;

    display_ctrl #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE),
        .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_next(btn_next),
        .auto_en(auto_en),
        .hold(hold),
        .disp_data(disp_data),
        .sel_out(sel_out),
        .page_changed(page_changed),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (page_changed === 1'b1) pc_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        dec = 7'bxxxxxxx;
        for (int i = 0; i < 16; i++) begin
            if (hex_tbl[i].nib == n) dec = hex_tbl[i].seg;
        end
    endfunction

    function automatic int an_index(input logic [7:0] a);
        an_index = -1;
        for (int d = 0; d < 8; d++) begin
            if (a == ~(8'd1 << d)) an_index = d;
        end
    endfunction

    task automatic applyStimulus(input logic b, input logic ae, input logic h, input logic [31:0] d);
        btn_next  = b;
        auto_en   = ae;
        hold      = h;
        disp_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Waits for sel_out to move, then checks latency, new page and pulse.
    task automatic checkAdvance(input string name, input int max_cycles, input int exp_cycles, input bit check_off);
        int         cyc;
        logic [2:0] prev;
        logic [2:0] exp_val;
        prev    = sel_out;
        exp_val = (exp_sel == 6) ? 3'd0 : 3'(exp_sel + 1);
        sel_sb.push_back(exp_val);
        cyc = -1;
        for (int k = 1; k <= max_cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel_out != prev) begin
                cyc = k;
                break;
            end
        end
        checkOutput({name, " latency"}, 32'(cyc), 32'(exp_cycles));
        exp_val = sel_sb.pop_front();
        checkOutput({name, " sel"}, 32'(sel_out), 32'(exp_val));
        checkOutput({name, " pulse"}, 32'(page_changed), 32'd1);
        exp_sel = int'(exp_val);
        if (check_off) begin
            @(negedge clk);
            checkOutput({name, " pulse end"}, 32'(page_changed), 32'd0);
        end
    endtask

    task automatic press(input string name);
        btn_next = 1'b1;
        checkAdvance(name, 30, 10, 1'b1);
        repeat (9) @(negedge clk);
        btn_next = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        logic [31:0] data;
        logic [15:0] exp_word;
        logic [3:0]  nib;
        logic [7:0]  seen;
        int          idx;
        int          bad;
        int          lit;
        int          pc_before;
        logic [2:0]  sel_before;

        hex_tbl[0]  = '{4'h0, 7'b1000000};
        hex_tbl[1]  = '{4'h1, 7'b1111001};
        hex_tbl[2]  = '{4'h2, 7'b0100100};
        hex_tbl[3]  = '{4'h3, 7'b0110000};
        hex_tbl[4]  = '{4'h4, 7'b0011001};
        hex_tbl[5]  = '{4'h5, 7'b0010010};
        hex_tbl[6]  = '{4'h6, 7'b0000010};
        hex_tbl[7]  = '{4'h7, 7'b1111000};
        hex_tbl[8]  = '{4'h8, 7'b0000000};
        hex_tbl[9]  = '{4'h9, 7'b0010000};
        hex_tbl[10] = '{4'hA, 7'b0001000};
        hex_tbl[11] = '{4'hB, 7'b0000011};
        hex_tbl[12] = '{4'hC, 7'b1000110};
        hex_tbl[13] = '{4'hD, 7'b0100001};
        hex_tbl[14] = '{4'hE, 7'b0000110};
        hex_tbl[15] = '{4'hF, 7'b0001110};

        // Reset state, then one full scan frame plus a bit.
        data  = 32'h1234ABCD;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, data);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset an", 32'(an), 32'h0000_00FF);
        checkOutput("reset seg", 32'(seg), 32'h0000_00FF);
        checkOutput("reset sel", 32'(sel_out), 32'd0);
        checkOutput("reset pulse", 32'(page_changed), 32'd0);
        reset = 1'b0;

        for (int n = 1; n <= 40; n++) begin
            idx = ((n - 1) / 4) % 8;
            nib = (n == 1) ? 4'h0 : data[idx*4 +: 4];
            scan_sb.push_back({~(8'd1 << idx), 1'b1, dec(nib)});
            @(posedge clk);
            @(negedge clk);
            exp_word = scan_sb.pop_front();
            checkOutput("scan an/seg", {16'd0, an, seg}, {16'd0, exp_word});
        end
        checkOutput("scan sel", 32'(sel_out), 32'd0);

        // Short glitch must not advance the page.
        pc_before = pc_count;
        btn_next  = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("glitch sel", 32'(sel_out), 32'd0);
        checkOutput("glitch pulses", 32'(pc_count - pc_before), 32'd0);

        // Eight clean presses walk 1,2,3,4,5,6,0,1.
        for (int p = 0; p < 8; p++) press("press");

        // Auto-rotate with dp monitoring.
        auto_en = 1'b1;
        bad = 0;
        lit = 0;
        fork
            checkAdvance("auto1", 40, 32, 1'b0);
            begin
                for (int k = 0; k < 32; k++) begin
                    @(negedge clk);
                    if ((an == 8'hFE) == seg[7]) bad++;
                    if (an == 8'hFE && !seg[7]) lit++;
                end
            end
        join
        checkOutput("auto dp rule", 32'(bad), 32'd0);
        checkOutput("auto dp lit seen", 32'(lit > 0), 32'd1);
        checkAdvance("auto2", 40, 32, 1'b0);

        repeat (20) @(negedge clk);
        sel_before = sel_out;
        auto_en    = 1'b0;
        bad        = 0;
        repeat (10) begin
            @(negedge clk);
            if (!seg[7]) bad++;
        end
        checkOutput("auto off dp", 32'(bad), 32'd0);
        checkOutput("auto off sel", 32'(sel_out), 32'(sel_before));
        auto_en = 1'b1;
        checkAdvance("auto re-enable", 40, 32, 1'b0);

        // Press lands on the same edge as the auto expiry.
        repeat (22) @(negedge clk);
        btn_next = 1'b1;
        checkAdvance("collision", 30, 10, 1'b1);
        repeat (9) @(negedge clk);
        btn_next = 1'b0;
        checkAdvance("timer restart", 40, 22, 1'b0);
        auto_en = 1'b0;
        repeat (4) @(negedge clk);

        // Full decode table.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, {8{hex_tbl[i].nib}});
            repeat (2) @(negedge clk);
            checkOutput("decode", 32'(seg), {24'd0, 1'b1, hex_tbl[i].seg});
        end

        // Hold freezes the shown value; pages still move.
        applyStimulus(1'b0, 1'b0, 1'b0, data);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        bad = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            idx = an_index(an);
            if (idx < 0) bad++;
            else if (seg[6:0] != dec(data[idx*4 +: 4])) bad++;
        end
        checkOutput("hold freeze", 32'(bad), 32'd0);
        press("press in hold");
        hold = 1'b0;
        bad  = 0;
        seen = 8'h00;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (seg[6:0] != 7'b0001110) bad++;
                idx = an_index(an);
                if (idx >= 0) seen[idx] = 1'b1;
            end
        end
        checkOutput("release shows F", 32'(bad), 32'd0);
        checkOutput("release all digits", 32'(seen), 32'h0000_00FF);

        // Reset mid-operation at page 5 with the button held.
        while (exp_sel != 5) press("to page 5");
        btn_next = 1'b1;
        auto_en  = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid reset an", 32'(an), 32'h0000_00FF);
        checkOutput("mid reset seg", 32'(seg), 32'h0000_00FF);
        checkOutput("mid reset sel", 32'(sel_out), 32'd0);
        checkOutput("mid reset pulse", 32'(page_changed), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        exp_sel = 0;
        checkAdvance("post-reset press", 30, 10, 1'b1);
        checkAdvance("post-reset auto", 40, 31, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
